// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state encoding and requester IDs for mem_arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;
  typedef enum logic {REQ_CPU = 1'b0, REQ_LDR = 1'b1} req_id_t;
  localparam int CNT_W = 4;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; bit 0 = CPU, bit 1 = loader.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  output logic [1:0] gnt
);
  always_comb begin
    gnt[0] = req[0] & (~req[1] | (last == REQ_LDR));
    gnt[1] = req[1] & (~req[0] | (last == REQ_CPU));
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the CPU and a loader, fixed-latency transfers.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_ack,
  output logic          mm_rd,
  output logic          mm_wr,
  output logic [AW-1:0] mm_addr,
  output logic [DW-1:0] mm_wdata,
  input  logic [DW-1:0] mm_rdata,
  output logic          busy
);
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_id_t           last_q, last_d, sel_q, sel_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d, crd_q, crd_d, lrd_q, lrd_d;
  logic [1:0]        gnt;

  rr_arbiter2 u_rr (
    .req  ({ldr_req, cpu_rd | cpu_wr}),
    .last (last_q),
    .gnt  (gnt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    crd_d   = crd_q;
    lrd_d   = lrd_q;
    case (state_q)
      IDLE: if (|gnt) begin
        sel_d   = gnt[1] ? REQ_LDR : REQ_CPU;
        last_d  = sel_d;
        we_d    = gnt[1] ? ldr_we : cpu_wr;
        addr_d  = gnt[1] ? ldr_addr : cpu_addr;
        wdata_d = gnt[1] ? ldr_wdata : cpu_wdata;
        state_d = ACCESS;
      end
      ACCESS: begin
        cnt_d   = CNT_W'(WAIT_STATES - 1);
        state_d = WAIT;
      end
      WAIT: if (cnt_q == '0) begin
        crd_d   = (!we_q && sel_q == REQ_CPU) ? mm_rdata : crd_q;
        lrd_d   = (!we_q && sel_q == REQ_LDR) ? mm_rdata : lrd_q;
        state_d = ACK;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset leaves last_grant at the loader so the CPU wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= REQ_LDR;
      sel_q   <= REQ_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      crd_q   <= '0;
      lrd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      crd_q   <= crd_d;
      lrd_q   <= lrd_d;
    end
  end

  assign busy      = state_q != IDLE;
  assign mm_rd     = !we_q && (state_q == ACCESS || state_q == WAIT);
  assign mm_wr     = we_q && state_q == ACCESS;
  assign cpu_ack   = state_q == ACK && sel_q == REQ_CPU;
  assign ldr_ack   = state_q == ACK && sel_q == REQ_LDR;
  assign mm_addr   = addr_q;
  assign mm_wdata  = wdata_q;
  assign cpu_rdata = crd_q;
  assign ldr_rdata = lrd_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: cycle-by-cycle vector table on a WAIT_STATES=1 instance, plus
// hand sequences for WAIT_STATES=4 latency and mid-transfer reset.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cpu_rd = 0, cpu_wr = 0, ldr_req = 0, ldr_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, ldr_addr = 0, ldr_wdata = 0, mm_rdata = 0;
  logic [31:0] cpu_rdata1, ldr_rdata1, mm_addr1, mm_wdata1;
  logic [31:0] cpu_rdata4, ldr_rdata4, mm_addr4, mm_wdata4;
  logic cpu_ack1, ldr_ack1, mm_rd1, mm_wr1, busy1;
  logic cpu_ack4, ldr_ack4, mm_rd4, mm_wr4, busy4;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WAIT_STATES(1)) dut1 (
    .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata1), .cpu_ack(cpu_ack1), .ldr_req(ldr_req),
    .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_rdata(ldr_rdata1),
    .ldr_ack(ldr_ack1), .mm_rd(mm_rd1), .mm_wr(mm_wr1), .mm_addr(mm_addr1),
    .mm_wdata(mm_wdata1), .mm_rdata(mm_rdata), .busy(busy1));

  mem_arbiter #(.WAIT_STATES(4)) dut4 (
    .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata4), .cpu_ack(cpu_ack4), .ldr_req(ldr_req),
    .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_rdata(ldr_rdata4),
    .ldr_ack(ldr_ack4), .mm_rd(mm_rd4), .mm_wr(mm_wr4), .mm_addr(mm_addr4),
    .mm_wdata(mm_wdata4), .mm_rdata(mm_rdata), .busy(busy4));

  // in = {cpu_rd, cpu_wr, ldr_req, ldr_we}; out = {mm_rd, mm_wr, cpu_ack, ldr_ack, busy}
  typedef struct {
    logic [3:0]  in;
    logic [31:0] ca, la, d, mrd;
    logic [4:0]  out;
    logic [31:0] crd, lrd, ma, mwd;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("one_ack_ws1", {31'b0, cpu_ack1 & ldr_ack1}, 0);
    chk("rdwr_ws1", {31'b0, mm_rd1 & mm_wr1}, 0);
    chk("one_ack_ws4", {31'b0, cpu_ack4 & ldr_ack4}, 0);
    chk("rdwr_ws4", {31'b0, mm_rd4 & mm_wr4}, 0);
  end

  initial begin
    int n, rdcnt;
    logic seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", {27'b0, mm_rd1, mm_wr1, cpu_ack1, ldr_ack1, busy1}, 0);
    chk("rst_maddr", mm_addr1, 0);
    chk("rst_crd", cpu_rdata1, 0);
    chk("rst_lrd", ldr_rdata1, 0);
    rst = 1'b1;
    // CPU read 0x40
    tv.push_back('{4'b1000, 'h40, 0, 0, 'hDEADBEEF, 5'b10001, 0, 0, 'h40, 0});
    tv.push_back('{4'b1000, 'h40, 0, 0, 'hDEADBEEF, 5'b10001, 0, 0, 'h40, 0});
    tv.push_back('{4'b1000, 'h40, 0, 0, 'hDEADBEEF, 5'b00101, 'hDEADBEEF, 0, 'h40, 0});
    tv.push_back('{4'b0000, 'h40, 0, 0, 'hDEADBEEF, 5'b00000, 'hDEADBEEF, 0, 'h40, 0});
    // loader write 0x10
    tv.push_back('{4'b0011, 0, 'h10, 'h12345678, 'hAAAA5555, 5'b01001, 'hDEADBEEF, 0, 'h10, 'h12345678});
    tv.push_back('{4'b0011, 0, 'h10, 'h12345678, 'hAAAA5555, 5'b00001, 'hDEADBEEF, 0, 'h10, 'h12345678});
    tv.push_back('{4'b0011, 0, 'h10, 'h12345678, 'hAAAA5555, 5'b00011, 'hDEADBEEF, 0, 'h10, 'h12345678});
    tv.push_back('{4'b0000, 0, 'h10, 'h12345678, 'hAAAA5555, 5'b00000, 'hDEADBEEF, 0, 'h10, 'h12345678});
    // both reading continuously: CPU, LDR, CPU, LDR
    tv.push_back('{4'b1010, 'h100, 'h200, 0, 'h11111111, 5'b10001, 'hDEADBEEF, 0, 'h100, 0});
    tv.push_back('{4'b1010, 'h100, 'h200, 0, 'h11111111, 5'b10001, 'hDEADBEEF, 0, 'h100, 0});
    tv.push_back('{4'b1010, 'h100, 'h200, 0, 'h11111111, 5'b00101, 'h11111111, 0, 'h100, 0});
    tv.push_back('{4'b1010, 'h100, 'h200, 0, 'h11111111, 5'b00000, 'h11111111, 0, 'h100, 0});
    tv.push_back('{4'b1010, 'h100, 'h200, 0, 'h22222222, 5'b10001, 'h11111111, 0, 'h200, 0});
    tv.push_back('{4'b1010, 'h100, 'h200, 0, 'h22222222, 5'b10001, 'h11111111, 0, 'h200, 0});
    tv.push_back('{4'b1010, 'h100, 'h200, 0, 'h22222222, 5'b00011, 'h11111111, 'h22222222, 'h200, 0});
    tv.push_back('{4'b1010, 'h100, 'h200, 0, 'h22222222, 5'b00000, 'h11111111, 'h22222222, 'h200, 0});
    tv.push_back('{4'b1010, 'h100, 'h200, 0, 'h33333333, 5'b10001, 'h11111111, 'h22222222, 'h100, 0});
    tv.push_back('{4'b1010, 'h100, 'h200, 0, 'h33333333, 5'b10001, 'h11111111, 'h22222222, 'h100, 0});
    tv.push_back('{4'b1010, 'h100, 'h200, 0, 'h33333333, 5'b00101, 'h33333333, 'h22222222, 'h100, 0});
    tv.push_back('{4'b1010, 'h100, 'h200, 0, 'h33333333, 5'b00000, 'h33333333, 'h22222222, 'h100, 0});
    tv.push_back('{4'b1010, 'h100, 'h200, 0, 'h44444444, 5'b10001, 'h33333333, 'h22222222, 'h200, 0});
    tv.push_back('{4'b1010, 'h100, 'h200, 0, 'h44444444, 5'b10001, 'h33333333, 'h22222222, 'h200, 0});
    tv.push_back('{4'b1010, 'h100, 'h200, 0, 'h44444444, 5'b00011, 'h33333333, 'h44444444, 'h200, 0});
    tv.push_back('{4'b1010, 'h100, 'h200, 0, 'h44444444, 5'b00000, 'h33333333, 'h44444444, 'h200, 0});
    // cpu_rd and cpu_wr together execute as a write
    tv.push_back('{4'b1100, 'h80, 0, 'hA5A5A5A5, 'h55555555, 5'b01001, 'h33333333, 'h44444444, 'h80, 'hA5A5A5A5});
    tv.push_back('{4'b1100, 'h80, 0, 'hA5A5A5A5, 'h55555555, 5'b00001, 'h33333333, 'h44444444, 'h80, 'hA5A5A5A5});
    tv.push_back('{4'b1100, 'h80, 0, 'hA5A5A5A5, 'h55555555, 5'b00101, 'h33333333, 'h44444444, 'h80, 'hA5A5A5A5});
    tv.push_back('{4'b0000, 'h80, 0, 'hA5A5A5A5, 'h55555555, 5'b00000, 'h33333333, 'h44444444, 'h80, 'hA5A5A5A5});
    for (int i = 0; i < tv.size(); i++) begin
      {cpu_rd, cpu_wr, ldr_req, ldr_we} = tv[i].in;
      cpu_addr = tv[i].ca;
      ldr_addr = tv[i].la;
      cpu_wdata = tv[i].d;
      ldr_wdata = tv[i].d;
      mm_rdata = tv[i].mrd;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ctl", i), {27'b0, mm_rd1, mm_wr1, cpu_ack1, ldr_ack1, busy1}, {27'b0, tv[i].out});
      chk($sformatf("v%0d_crd", i), cpu_rdata1, tv[i].crd);
      chk($sformatf("v%0d_lrd", i), ldr_rdata1, tv[i].lrd);
      chk($sformatf("v%0d_maddr", i), mm_addr1, tv[i].ma);
      chk($sformatf("v%0d_mwdata", i), mm_wdata1, tv[i].mwd);
    end
    // WAIT_STATES=4: address changed after grant, ack 5 edges after the grant edge
    rst = 1'b0;
    #2;
    rst = 1'b1;
    cpu_rd = 1;
    cpu_addr = 'h60;
    mm_rdata = 'h77777777;
    @(posedge clk);
    #1;
    cpu_addr = 'h99;
    rdcnt = int'(mm_rd4);
    n = 0;
    while (!cpu_ack4 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      rdcnt += int'(mm_rd4);
    end
    chk("ws4_latency", n, 5);
    chk("ws4_rd_cycles", rdcnt, 5);
    chk("ws4_maddr", mm_addr4, 'h60);
    chk("ws4_rdata", cpu_rdata4, 'h77777777);
    cpu_rd = 0;
    cpu_addr = 0;
    @(posedge clk);
    #1;
    // reset during WAIT of a loader read
    rst = 1'b0;
    #2;
    rst = 1'b1;
    ldr_req = 1;
    ldr_we = 0;
    ldr_addr = 'h30;
    mm_rdata = 'hBBBBBBBB;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_busy", {31'b0, busy1}, 1);
    chk("pre_rst_rd", {31'b0, mm_rd1}, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_ctl", {27'b0, mm_rd1, mm_wr1, cpu_ack1, ldr_ack1, busy1}, 0);
    chk("rst_mid_maddr", mm_addr1, 0);
    ldr_req = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      seen |= ldr_ack1 | busy1;
    end
    chk("no_resume", {31'b0, seen}, 0);
    chk("no_capture", ldr_rdata1, 0);
    cpu_rd = 1;
    ldr_req = 1;
    cpu_addr = 'h70;
    @(posedge clk);
    #1;
    chk("tie_maddr", mm_addr1, 'h70);
    n = 0;
    while (!(cpu_ack1 | ldr_ack1) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("tie_acks", {30'b0, cpu_ack1, ldr_ack1}, 2);
    chk("tie_latency", n, 2);
    cpu_rd = 0;
    ldr_req = 0;
    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_STATES, default 1, giving the memory access cycles per transfer, legal range 1..15.
REQ-002 The block SHALL have parameter AW, default 32, giving the address width.
REQ-003 The block SHALL have parameter DW, default 32, giving the data width.
REQ-004 clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 cpu_rd  in  1  control-section read request, level, held until cpu_ack.
REQ-007 cpu_wr  in  1  control-section write request, level, held until cpu_ack.
REQ-008 cpu_addr  in  AW  control-section address.
REQ-009 cpu_wdata  in  DW  control-section write data.
REQ-010 cpu_rdata  out  DW  last data read for the CPU, registered.
REQ-011 cpu_ack  out  1  one-cycle completion pulse to the control section.
REQ-012 ldr_req  in  1  loader/debug request, level, held until ldr_ack.
REQ-013 ldr_we  in  1  loader write enable: 1 = write, 0 = read.
REQ-014 ldr_addr  in  AW  loader address.
REQ-015 ldr_wdata  in  DW  loader write data.
REQ-016 ldr_rdata  out  DW  last data read for the loader, registered.
REQ-017 ldr_ack  out  1  one-cycle completion pulse to the loader.
REQ-018 mm_rd  out  1  main-memory read strobe.
REQ-019 mm_wr  out  1  main-memory write strobe.
REQ-020 mm_addr  out  AW  main-memory address, registered.
REQ-021 mm_wdata  out  DW  main-memory write data, registered.
REQ-022 mm_rdata  in  DW  main-memory read data.
REQ-023 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-024 The FSM SHALL have the states IDLE, ACCESS, WAIT and ACK.
REQ-025 IDLE SHALL be the only state that samples requests.
- CPU request = cpu_rd | cpu_wr.
- If no request is present, the FSM SHALL stay in IDLE.
REQ-026 If exactly one requester is active in IDLE, that requester SHALL be granted.
REQ-027 If both requesters are active in IDLE, the requester not granted last SHALL be granted (round-robin).
- last_grant SHALL update on every grant.
REQ-028 On grant, the block SHALL latch the address, write data and direction into mm_addr, mm_wdata and an internal we register, then go to ACCESS.
- Later changes on the requester's inputs SHALL NOT affect the transfer in progress.
REQ-029 cpu_rd and cpu_wr high together SHALL be executed as a write.
REQ-030 ACCESS SHALL last one cycle.
- Write: mm_wr = 1 for exactly this cycle.
- Read: mm_rd = 1.
- The wait counter SHALL load WAIT_STATES-1.
- Next state: WAIT.
REQ-031 In WAIT, mm_rd SHALL stay high for reads and the counter SHALL decrement each cycle.
- When the counter is 0, read data from mm_rdata SHALL be captured into the granted requester's rdata register, and the next state is ACK.
- A write SHALL pass through WAIT with no capture.
REQ-032 ACK SHALL pulse the granted requester's ack for exactly one cycle with mm_rd = mm_wr = 0, then return to IDLE.
REQ-033 Latency SHALL be fixed: a request sampled in IDLE at cycle T gives ack at cycle T+2+WAIT_STATES.
REQ-034 A request withdrawn after grant SHALL still be completed and acknowledged.
REQ-035 Each rdata register SHALL hold its value until the next read by the same requester; writes SHALL NOT alter rdata.
REQ-036 mm_rd and mm_wr SHALL never be high in the same cycle.
REQ-037 At most one ack SHALL be high in any cycle.
REQ-038 busy SHALL be 0 in IDLE and 1 in all other states.

Reset
REQ-039 rst low SHALL immediately force the following, including mid-transfer:
- state = IDLE
- all outputs = 0
- counter = 0
- last_grant = loader, so the CPU wins the first tie
REQ-040 A transfer aborted by reset SHALL produce no ack and SHALL NOT be resumed.

Structure
REQ-041 Package mem_arb_pkg SHALL hold the state encoding and the requester IDs (REQ_CPU, REQ_LDR).
REQ-042 The grant decision SHALL be one sub-module, rr_arbiter2, taking two requests and last_grant and returning a one-hot grant; everything else stays in mem_arbiter.

Verification
REQ-043 CPU read, WAIT_STATES=1, mm_rdata=0xDEADBEEF, addr 0x40 -> mm_addr=0x40, mm_rd high 2 cycles, cpu_ack 3 cycles after request, cpu_rdata=0xDEADBEEF.
REQ-044 Loader write, addr 0x10, data 0x12345678 -> mm_wr high exactly 1 cycle with mm_wdata=0x12345678, ldr_ack once, ldr_rdata unchanged.
REQ-045 Both requesting continuously from reset -> grants alternate CPU, LDR, CPU, LDR; never two acks in one cycle.
REQ-046 WAIT_STATES=4, CPU read, cpu_addr changed to 0x99 after grant -> mm_addr keeps its original value, cpu_ack at T+6.
REQ-047 rst low during WAIT of a loader read -> mm_rd, busy and ack drop immediately; no ldr_ack; after release the FSM is in IDLE and the CPU wins the next tie.
REQ-048 cpu_rd=cpu_wr=1 -> a write is performed with mm_rd = 0 throughout.
